// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to let lock_i[grant_o] hold the channel for its owner.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [8*NUM_REQ-1:0] data_i,
    input  logic [NUM_REQ-1:0]   lock_i,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [IDX_W-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 tx_stb_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    input  logic                 tx_done_i
);

    // state     | meaning
    // IDLE      | waiting for an eligible request while uart_tx is idle
    // ISSUE     | byte latched; strobe/ack registered out this cycle
    // WAIT_BUSY | strobe sent; waiting for uart_tx to report busy (or done)
    // WAIT_DONE | frame in flight; waiting for uart_tx done
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] owner_mask;
    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;

    assign owner_mask = NUM_REQ'(1) << grant_o;

`ifdef UART_ARB_LOCK_EN
    always_comb begin
        eligible = req_i;
        if (lock_i[grant_o]) begin
            eligible = req_i & owner_mask;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
    assign eligible    = req_i;
`endif

    // Search starts one past the last owner and wraps explicitly, so NUM_REQ need not be 2^n.
    always_comb begin
        found    = 1'b0;
        sel      = grant_o;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(grant_o) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && eligible[cand_idx]) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            grant_o   <= IDX_W'(NUM_REQ - 1);
            ack_o     <= '0;
            done_o    <= '0;
            busy_o    <= 1'b0;
            tx_stb_o  <= 1'b0;
            tx_data_o <= '0;
        end else begin
            ack_o    <= '0;
            done_o   <= '0;
            tx_stb_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !tx_busy_i) begin
                        grant_o   <= sel;
                        tx_data_o <= data_i[8*sel +: 8];
                        busy_o    <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                ISSUE: begin
                    tx_stb_o <= 1'b1;
                    ack_o    <= owner_mask;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_done_i) begin
                        done_o <= owner_mask;
                        state  <= IDLE;
                    end else if (tx_busy_i) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done_i) begin
                        done_o <= owner_mask;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx model per instance.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int FRAME = 12;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req = '0, lock = '0;
    logic [8*N-1:0] data = '0;
    logic [N-1:0]   ack, done;
    logic [1:0]     grant;
    logic           busy, stb;
    logic [7:0]     txd;
    logic           ubusy = 1'b0, udone = 1'b0;
    int             ucnt = 0;

    logic [2:0]  req3 = '0, lock3 = '0;
    logic [23:0] data3 = '0;
    logic [2:0]  ack3, done3;
    logic [1:0]  grant3;
    logic        busy3, stb3;
    logic [7:0]  txd3;
    logic        ubusy3 = 1'b0, udone3 = 1'b0;
    int          ucnt3 = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .lock_i(lock),
        .ack_o(ack), .done_o(done), .grant_o(grant), .busy_o(busy),
        .tx_stb_o(stb), .tx_data_o(txd), .tx_busy_i(ubusy), .tx_done_i(udone)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .IDX_W(2)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .data_i(data3), .lock_i(lock3),
        .ack_o(ack3), .done_o(done3), .grant_o(grant3), .busy_o(busy3),
        .tx_stb_o(stb3), .tx_data_o(txd3), .tx_busy_i(ubusy3), .tx_done_i(udone3)
    );

    // uart_tx stand-ins: never reset by rst, busy for FRAME cycles, done as busy falls
    always @(posedge clk) begin
        udone <= 1'b0;
        if (ubusy) begin
            if (ucnt == 1) begin
                ubusy <= 1'b0;
                udone <= 1'b1;
            end
            ucnt <= ucnt - 1;
        end else if (stb) begin
            ubusy <= 1'b1;
            ucnt  <= FRAME;
        end
    end

    always @(posedge clk) begin
        udone3 <= 1'b0;
        if (ubusy3) begin
            if (ucnt3 == 1) begin
                ubusy3 <= 1'b0;
                udone3 <= 1'b1;
            end
            ucnt3 <= ucnt3 - 1;
        end else if (stb3) begin
            ubusy3 <= 1'b1;
            ucnt3  <= FRAME;
        end
    end

    int   checks = 0, failures = 0;
    exp_t expq[$];
    exp_t src[$];
    int   exp3[$];
    int   inflight = 0, owner = 0;
    int   stb_cnt = 0, done_cnt = 0;
    int   cyc = 0, last_done_cyc = -100;
    int   n3 = 0, d3 = 0;
    bit   lock_mode = 1'b0, withdraw2 = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", tag, got, exp);
        end
    endtask

    task automatic update_reqs();
        int j;
        req = '0;
        for (int i = 0; i < src.size(); i++) begin
            j = src[i].idx;
            if (!req[j]) begin
                req[j]        = 1'b1;
                data[8*j +: 8] = 8'(src[i].data);
            end
        end
        lock    = '0;
        lock[1] = lock_mode && req[1];
    endtask

    // One cycle: sample outputs at the falling edge, score them, then update requesters.
    task automatic tick();
        exp_t e;
        bit   hit;
        @(negedge clk);
        cyc++;
        if (stb) begin
            stb_cnt++;
            if (expq.size() == 0) begin
                check_val("unexpected_stb", 1, 0);
            end else begin
                e = expq.pop_front();
                check_val("grant", int'(grant), e.idx);
                check_val("tx_data", int'(txd), e.data);
                check_val("ack_onehot", int'(ack), 1 << e.idx);
            end
            check_val("one_stb_per_done", inflight, 0);
            check_val("b2b_gap_ok", int'((cyc - last_done_cyc) >= 2), 1);
            inflight = 1;
            owner    = int'(grant);
            for (int j = 0; j < N; j++) begin
                if (ack[j]) begin
                    hit = 1'b0;
                    for (int i = 0; i < src.size(); i++) begin
                        if (!hit && src[i].idx == j) begin
                            src.delete(i);
                            hit = 1'b1;
                        end
                    end
                end
            end
        end else if (ack != 0) begin
            check_val("ack_without_stb", int'(ack), 0);
        end
        if (done != 0) begin
            done_cnt++;
            check_val("done_owner", int'(done), 1 << owner);
            check_val("done_has_frame", inflight, 1);
            check_val("busy_in_done_cycle", int'(busy), 1);
            inflight      = 0;
            last_done_cyc = cyc;
        end
        if (withdraw2 && busy) begin
            src.delete();
            data[23:16] = 8'hEE;
            withdraw2   = 1'b0;
        end
        update_reqs();
        if (stb3) begin
            n3++;
            check_val("grant3_range", int'(grant3 < 2'd3), 1);
            if (exp3.size() == 0) begin
                check_val("unexpected_stb3", 1, 0);
            end else begin
                e.idx = exp3.pop_front();
                check_val("grant3", int'(grant3), e.idx);
                check_val("tx_data3", int'(txd3), 8'hC0 + e.idx);
            end
            if (n3 == 4) req3 = '0;
        end
        if (done3 != 0) begin
            d3++;
            check_val("done3_grant_range", int'(grant3 < 2'd3), 1);
        end
    endtask

    task automatic check_reset_vals();
        check_val("rst_grant", int'(grant), N - 1);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_stb", int'(stb), 0);
        check_val("rst_ack", int'(ack), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_tx_data", int'(txd), 0);
        check_val("rst_grant3", int'(grant3), 2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check_reset_vals();
        rst           = 1'b0;
        inflight      = 0;
        last_done_cyc = -100;
        stb_cnt       = 0;
        done_cnt      = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((expq.size() != 0 || src.size() != 0 || inflight != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, int'(expq.size() == 0 && src.size() == 0 && inflight == 0 && !busy), 1);
    endtask

    task automatic end_test(input string tag, input int nstb, input int ndone);
        check_val({tag, "_stb_count"}, stb_cnt, nstb);
        check_val({tag, "_done_count"}, done_cnt, ndone);
    endtask

    task automatic add(input int idx, input int d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        src.push_back(e);
        expq.push_back(e);
    endtask

    initial begin
        int n;
        int snap;
        exp_t e;

        // single request
        do_reset();
        add(0, 8'h32);
        update_reqs();
        n = 0;
        do begin
            tick();
            n++;
        end while (!stb && n < 20);
        check_val("req_to_stb_latency", n, 2);
        drain("single_drained", 200);
        end_test("single", 1, 1);

        // contention: 0,1,2,3,0
        do_reset();
        add(0, 8'hA0); add(1, 8'hA1); add(2, 8'hA2); add(3, 8'hA3); add(0, 8'hA0);
        update_reqs();
        drain("contention_drained", 400);
        end_test("contention", 5, 5);

        // three requesters: 0,1,2,0
        req3  = 3'b111;
        data3 = {8'hC2, 8'hC1, 8'hC0};
        exp3  = '{0, 1, 2, 0};
        n = 0;
        while ((n3 < 4 || d3 < 4 || busy3) && n < 400) begin
            tick();
            n++;
        end
        check_val("nr3_drained", int'(n3 == 4 && d3 == 4 && !busy3 && exp3.size() == 0), 1);

        // reset during WAIT_DONE; uart_tx keeps running
        do_reset();
        add(0, 8'h55);
        update_reqs();
        n = 0;
        while (!(ubusy && inflight == 1) && n < 50) begin
            tick();
            n++;
        end
        check_val("midframe_uart_started", int'(ubusy), 1);
        repeat (3) tick();
        rst = 1'b1;
        add(0, 8'h66);
        update_reqs();
        tick();
        check_reset_vals();
        check_val("midframe_uart_still_busy", int'(ubusy), 1);
        rst      = 1'b0;
        inflight = 0;
        snap     = stb_cnt;
        n = 0;
        while (ubusy && n < 50) begin
            tick();
            n++;
        end
        check_val("no_stb_while_uart_busy", stb_cnt, snap);
        drain("midframe_drained", 200);
        end_test("midframe", 2, 1);

        // lock: requester 1 sends 3 bytes under lock, requester 2 one byte
        do_reset();
        lock_mode = 1'b1;
        e.idx = 1; e.data = 8'h11; src.push_back(e);
        e.data = 8'h12; src.push_back(e);
        e.data = 8'h13; src.push_back(e);
        e.idx = 2; e.data = 8'h22; src.push_back(e);
`ifdef UART_ARB_LOCK_EN
        expq = '{'{1, 8'h11}, '{1, 8'h12}, '{1, 8'h13}, '{2, 8'h22}};
`else
        expq = '{'{1, 8'h11}, '{2, 8'h22}, '{1, 8'h12}, '{1, 8'h13}};
`endif
        update_reqs();
        drain("lock_drained", 400);
        end_test("lock", 4, 4);
        lock_mode = 1'b0;

        // early withdrawal of requester 2 right after selection
        do_reset();
        add(2, 8'h77);
        withdraw2 = 1'b1;
        update_reqs();
        drain("withdraw_drained", 200);
        end_test("withdraw", 1, 1);
        check_val("withdraw_req_dropped", int'(req[2]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
